// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//   ICACHE_INDEX_WIDTH : log2 of the number of direct-mapped entries
//   ICACHE_ADDR_WIDTH  : PC width
//   state_t            : controller states (idle lookup / outstanding miss)
//   is_compressed()    : flags a 16-bit RVC encoding from the low opcode bits
package icache_pkg;

  localparam int ICACHE_INDEX_WIDTH = 6;
  localparam int ICACHE_ADDR_WIDTH  = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  function automatic logic is_compressed(input logic [31:0] inst);
    return inst[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache.
// Ports:
//   clk_in, rst_in           : clock, asynchronous active-low reset
//   rd_index_in              : lookup index (combinational read)
//   rd_valid_out/rd_tag_out  : entry valid bit and stored tag
//   rd_data_out/rd_is_c_out  : stored instruction word and compressed flag
//   wr_en_in, wr_index_in    : fill strobe and target entry
//   wr_tag_in, wr_data_in,
//   wr_is_c_in               : contents written on a fill
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int TAG_WIDTH   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [INDEX_WIDTH-1:0] rd_index_in,
  output logic                   rd_valid_out,
  output logic [TAG_WIDTH-1:0]   rd_tag_out,
  output logic [31:0]            rd_data_out,
  output logic                   rd_is_c_out,
  input  logic                   wr_en_in,
  input  logic [INDEX_WIDTH-1:0] wr_index_in,
  input  logic [TAG_WIDTH-1:0]   wr_tag_in,
  input  logic [31:0]            wr_data_in,
  input  logic                   wr_is_c_in
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  logic [TAG_WIDTH-1:0] tag_q [ENTRIES];
  logic [31:0]          data_q [ENTRIES];
  logic [ENTRIES-1:0]   is_c_q;

  // Only the valid bits need a reset; a cleared entry never exposes its payload.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_in) valid_d[wr_index_in] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      tag_q[wr_index_in]  <= wr_tag_in;
      data_q[wr_index_in] <= wr_data_in;
      is_c_q[wr_index_in] <= wr_is_c_in;
    end
  end

  assign rd_valid_out = valid_q[rd_index_in];
  assign rd_tag_out   = tag_q[rd_index_in];
  assign rd_data_out  = data_q[rd_index_in];
  assign rd_is_c_out  = is_c_q[rd_index_in];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and the memory controller.
// Hits return one cycle after the request; misses issue one read and fill
// the entry when the memory controller answers.
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-low reset
//   rdy_in                : global ready; low freezes all state
//   need_flush_in         : pipeline flush, abandons any pending miss
//   fetch_valid_in/_pc_in : fetch request (halfword-aligned PC)
//   inst_ready_out        : one-cycle pulse, inst_* outputs valid
//   inst_out/_pc_out      : returned instruction and its PC
//   inst_is_c_out         : returned instruction is compressed
//   ic_valid/ic_aout      : read request to the memory controller
//   iout_ready/mem_out    : memory controller response pulse and data
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  need_flush_in,
  input  logic                  fetch_valid_in,
  input  logic [ADDR_WIDTH-1:0] fetch_pc_in,
  output logic                  inst_ready_out,
  output logic [31:0]           inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out,
  output logic                  inst_is_c_out,
  output logic                  ic_valid,
  output logic [31:0]           ic_aout,
  input  logic                  iout_ready,
  input  logic [31:0]           mem_out
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] miss_pc_q, miss_pc_d;
  logic                  inst_ready_q, inst_ready_d;
  logic [31:0]           inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  inst_is_c_q, inst_is_c_d;
  logic                  fill_en;

  logic                  rd_valid;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic [31:0]           rd_data;
  logic                  rd_is_c;
  logic                  hit;

  icache_array #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_array (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rd_index_in (fetch_pc_in[INDEX_WIDTH:1]),
    .rd_valid_out(rd_valid),
    .rd_tag_out  (rd_tag),
    .rd_data_out (rd_data),
    .rd_is_c_out (rd_is_c),
    .wr_en_in    (fill_en),
    .wr_index_in (miss_pc_q[INDEX_WIDTH:1]),
    .wr_tag_in   (miss_pc_q[ADDR_WIDTH-1:INDEX_WIDTH+1]),
    .wr_data_in  (mem_out),
    .wr_is_c_in  (is_compressed(mem_out))
  );

  assign hit = rd_valid && (rd_tag == fetch_pc_in[ADDR_WIDTH-1:INDEX_WIDTH+1]);

  // Next-state logic. The cycle in which inst_ready is already high is skipped
  // so fetch can move its PC without being served twice. A flush overrides
  // everything except the fill write, whose data is still correct for miss_pc.
  always_comb begin
    state_d      = state_q;
    miss_pc_d    = miss_pc_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_is_c_d  = inst_is_c_q;
    fill_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fetch_valid_in && !inst_ready_q && !need_flush_in) begin
          if (hit) begin
            inst_ready_d = 1'b1;
            inst_d       = rd_data;
            inst_pc_d    = fetch_pc_in;
            inst_is_c_d  = rd_is_c;
          end else begin
            miss_pc_d = fetch_pc_in;
            state_d   = ST_MISS;
          end
        end
      end
      default: begin
        if (iout_ready) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
          if (!need_flush_in) begin
            inst_ready_d = 1'b1;
            inst_d       = mem_out;
            inst_pc_d    = miss_pc_q;
            inst_is_c_d  = is_compressed(mem_out);
          end
        end
      end
    endcase

    if (need_flush_in) state_d = ST_IDLE;
    if (!rdy_in)       fill_en = 1'b0;
  end

  // All controller state, including the ready pulse, freezes while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      miss_pc_q    <= '0;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_is_c_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      miss_pc_q    <= miss_pc_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_is_c_q  <= inst_is_c_d;
    end
  end

  // The request drops combinationally on the response or a flush so the
  // memory controller never starts a duplicate read at that edge.
  assign ic_valid       = (state_q == ST_MISS) && !iout_ready && !need_flush_in;
  assign ic_aout        = 32'(miss_pc_q);
  assign inst_ready_out = inst_ready_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = inst_pc_q;
  assign inst_is_c_out  = inst_is_c_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hit, compressed entries,
// index conflicts, flush during a miss and with a fill, ready stall, and
// reset during a miss.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        fetch_valid_in;
  logic [31:0] fetch_pc_in;
  logic        inst_ready_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        inst_is_c_out;
  logic        ic_valid;
  logic [31:0] ic_aout;
  logic        iout_ready;
  logic [31:0] mem_out;

  int total = 0;
  int bad   = 0;

  icache dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .need_flush_in (need_flush_in),
    .fetch_valid_in(fetch_valid_in),
    .fetch_pc_in   (fetch_pc_in),
    .inst_ready_out(inst_ready_out),
    .inst_out      (inst_out),
    .inst_pc_out   (inst_pc_out),
    .inst_is_c_out (inst_is_c_out),
    .ic_valid      (ic_valid),
    .ic_aout       (ic_aout),
    .iout_ready    (iout_ready),
    .mem_out       (mem_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance past the next rising edge; inputs change and outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full miss transaction: request, memory latency, fill pulse, and the
  // skipped cycle right after the pulse while fetch still holds its request.
  task automatic do_miss(input logic [31:0] pc, input logic [31:0] data,
                         input logic is_c, input int latency);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    tick();
    check_output("miss_ic_valid", ic_valid, 1);
    check_output("miss_ic_aout", ic_aout, pc);
    check_output("miss_no_ready", inst_ready_out, 0);
    for (int i = 0; i < latency; i++) begin
      tick();
      check_output("miss_wait_valid", ic_valid, 1);
    end
    iout_ready = 1'b1;
    mem_out    = data;
    #1;
    check_output("miss_valid_drop", ic_valid, 0);
    tick();
    iout_ready = 1'b0;
    check_output("fill_ready", inst_ready_out, 1);
    check_output("fill_inst", inst_out, data);
    check_output("fill_pc", inst_pc_out, pc);
    check_output("fill_is_c", inst_is_c_out, is_c);
    tick();
    check_output("post_fill_no_reserve", inst_ready_out, 0);
    check_output("post_fill_no_req", ic_valid, 0);
    fetch_valid_in = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] data, input logic is_c);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    tick();
    check_output("hit_ready", inst_ready_out, 1);
    check_output("hit_inst", inst_out, data);
    check_output("hit_pc", inst_pc_out, pc);
    check_output("hit_is_c", inst_is_c_out, is_c);
    check_output("hit_no_req", ic_valid, 0);
    tick();
    check_output("post_hit_no_reserve", inst_ready_out, 0);
    fetch_valid_in = 1'b0;
  endtask

  initial begin
    rst_in         = 1'b0;
    rdy_in         = 1'b1;
    need_flush_in  = 1'b0;
    fetch_valid_in = 1'b0;
    fetch_pc_in    = '0;
    iout_ready     = 1'b0;
    mem_out        = '0;
    #1;
    check_output("rst_ready", inst_ready_out, 0);
    check_output("rst_inst", inst_out, 0);
    check_output("rst_pc", inst_pc_out, 0);
    check_output("rst_is_c", inst_is_c_out, 0);
    check_output("rst_ic_valid", ic_valid, 0);
    check_output("rst_ic_aout", ic_aout, 0);
    tick();
    rst_in = 1'b1;
    tick();

    // Cold miss with a 5-cycle memory response, then a hit on the same PC.
    do_miss(32'h0000_0000, 32'h0000_0513, 1'b0, 4);
    do_hit(32'h0000_0000, 32'h0000_0513, 1'b0);

    // Compressed and full-width instructions in neighbouring halfword entries.
    do_miss(32'h0000_0004, 32'h0000_4501, 1'b1, 1);
    do_miss(32'h0000_0006, 32'h00A0_0593, 1'b0, 2);
    do_hit(32'h0000_0004, 32'h0000_4501, 1'b1);
    do_hit(32'h0000_0006, 32'h00A0_0593, 1'b0);

    // 0x80 shares index 0 with 0x0; each evicts the other.
    do_miss(32'h0000_0080, 32'h0010_0093, 1'b0, 2);
    do_hit(32'h0000_0080, 32'h0010_0093, 1'b0);
    do_miss(32'h0000_0000, 32'h0000_0513, 1'b0, 1);
    do_hit(32'h0000_0000, 32'h0000_0513, 1'b0);

    // Flush two cycles into a miss: request drops at once, no pulse.
    fetch_valid_in = 1'b1;
    fetch_pc_in    = 32'h0000_0010;
    tick();
    check_output("flush_req_up", ic_valid, 1);
    tick();
    check_output("flush_req_held", ic_valid, 1);
    need_flush_in  = 1'b1;
    fetch_valid_in = 1'b0;
    #1;
    check_output("flush_req_drop", ic_valid, 0);
    tick();
    need_flush_in = 1'b0;
    check_output("flush_no_ready", inst_ready_out, 0);
    #1;
    check_output("flush_idle", ic_valid, 0);
    tick();
    check_output("flush_still_idle", ic_valid, 0);
    do_miss(32'h0000_0010, 32'h0000_0297, 1'b0, 1);

    // Flush coinciding with the response: entry is filled, no pulse.
    fetch_valid_in = 1'b1;
    fetch_pc_in    = 32'h0000_0020;
    tick();
    check_output("flfill_req", ic_valid, 1);
    iout_ready     = 1'b1;
    mem_out        = 32'h0000_6108;
    need_flush_in  = 1'b1;
    fetch_valid_in = 1'b0;
    #1;
    check_output("flfill_req_drop", ic_valid, 0);
    tick();
    iout_ready    = 1'b0;
    need_flush_in = 1'b0;
    check_output("flfill_no_ready", inst_ready_out, 0);
    tick();
    do_hit(32'h0000_0020, 32'h0000_6108, 1'b1);

    // rdy_in low during a miss and during the fill pulse: everything freezes.
    fetch_valid_in = 1'b1;
    fetch_pc_in    = 32'h0000_0042;
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stall_miss_req", ic_valid, 1);
      check_output("stall_miss_addr", ic_aout, 32'h0000_0042);
      check_output("stall_miss_ready", inst_ready_out, 0);
    end
    rdy_in     = 1'b1;
    iout_ready = 1'b1;
    mem_out    = 32'h0000_8082;
    tick();
    iout_ready = 1'b0;
    check_output("stall_fill_ready", inst_ready_out, 1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stall_pulse_held", inst_ready_out, 1);
      check_output("stall_inst_held", inst_out, 32'h0000_8082);
      check_output("stall_pc_held", inst_pc_out, 32'h0000_0042);
    end
    rdy_in = 1'b1;
    tick();
    check_output("stall_pulse_end", inst_ready_out, 0);
    fetch_valid_in = 1'b0;
    tick();

    // Reset during a miss clears outputs immediately and invalidates all entries.
    fetch_valid_in = 1'b1;
    fetch_pc_in    = 32'h0000_0100;
    tick();
    check_output("rstmiss_req", ic_valid, 1);
    rst_in = 1'b0;
    #1;
    check_output("rstmiss_req_drop", ic_valid, 0);
    check_output("rstmiss_ready", inst_ready_out, 0);
    check_output("rstmiss_aout", ic_aout, 0);
    check_output("rstmiss_inst", inst_out, 0);
    fetch_valid_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    do_miss(32'h0000_0020, 32'h0000_6108, 1'b1, 1);
    do_miss(32'h0000_0000, 32'h0000_0513, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
